// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: shared state encoding for the AXI4-Stream register slice
package axi4_stream_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;
endpackage

// File: rtl/axi4_stream_skid.sv
// axi4_stream_skid: full AXI4-Stream register slice with registered TREADY and one-beat skid buffer
module axi4_stream_skid
  import axi4_stream_pkg::*;
#(
  parameter int DN = 1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [8*DN-1:0] sti_TDATA,
  input  logic [DN-1:0] sti_TKEEP,
  input  logic          sti_TLAST,
  input  logic          sti_TVALID,
  output logic          sti_TREADY,
  output logic [8*DN-1:0] sto_TDATA,
  output logic [DN-1:0] sto_TKEEP,
  output logic          sto_TLAST,
  output logic          sto_TVALID,
  input  logic          sto_TREADY,
  output logic [1:0]    occ
);
  localparam int PW = 8*DN + DN + 1;
  skid_state_t state, nxt;
  logic valid, ready, in_xfer, out_xfer, load_m, load_s, sel_s;
  logic [PW-1:0] m, s, din;
  assign din = {sti_TDATA, sti_TKEEP, sti_TLAST};
  assign in_xfer = sti_TVALID & ready;
  assign out_xfer = valid & sto_TREADY;
  // next-state decode and load enables for the main and skid registers
  always_comb begin
    nxt = state;
    load_m = 1'b0;
    load_s = 1'b0;
    sel_s = 1'b0;
    case (state)
      EMPTY: begin
        load_m = in_xfer;
        nxt = in_xfer ? BUSY : EMPTY;
      end
      BUSY: begin
        load_m = in_xfer & out_xfer;
        load_s = in_xfer & ~out_xfer;
        nxt = load_s ? FULL : (out_xfer & ~in_xfer) ? EMPTY : BUSY;
      end
      FULL: begin
        load_m = out_xfer;
        sel_s = 1'b1;
        nxt = out_xfer ? BUSY : FULL;
      end
      default: nxt = EMPTY;
    endcase
  end
  // control flops; valid and ready come straight from flops so no input reaches an output
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= EMPTY;
      valid <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= nxt;
      valid <= (nxt != EMPTY);
      ready <= (nxt != FULL);
    end
  end
  // payload flops carry no reset; contents are meaningless while not valid
  always_ff @(posedge ACLK) begin
    if (load_m) m <= sel_s ? s : din;
    if (load_s) s <= din;
  end
  assign {sto_TDATA, sto_TKEEP, sto_TLAST} = m;
  assign sto_TVALID = valid;
  assign sti_TREADY = ready;
  assign occ = state;
endmodule

// File: tb/tb_axi4_stream_skid.sv
// tb_axi4_stream_skid: scenario tasks plus randomized scoreboard for the stream register slice
module tb_axi4_stream_skid;
  localparam int DN = 2;
  localparam int PW = 8*DN + DN + 1;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [8*DN-1:0] sti_TDATA = '0;
  logic [DN-1:0] sti_TKEEP = '0;
  logic sti_TLAST = 1'b0;
  logic sti_TVALID = 1'b0;
  logic sti_TREADY;
  logic [8*DN-1:0] sto_TDATA;
  logic [DN-1:0] sto_TKEEP;
  logic sto_TLAST;
  logic sto_TVALID;
  logic sto_TREADY = 1'b0;
  logic [1:0] occ;
  logic [PW-1:0] sto;
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] q[$];
  bit rdy_seen = 1'b0;
  bit acc = 1'b0;
  int n_out = 0;

  axi4_stream_skid #(.DN(DN)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .sti_TDATA(sti_TDATA), .sti_TKEEP(sti_TKEEP), .sti_TLAST(sti_TLAST),
    .sti_TVALID(sti_TVALID), .sti_TREADY(sti_TREADY),
    .sto_TDATA(sto_TDATA), .sto_TKEEP(sto_TKEEP), .sto_TLAST(sto_TLAST),
    .sto_TVALID(sto_TVALID), .sto_TREADY(sto_TREADY), .occ(occ)
  );

  assign sto = {sto_TDATA, sto_TKEEP, sto_TLAST};

  always #5 ACLK = ~ACLK;

  // reference model: FIFO of accepted beats, emptied by reset
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      q.delete();
      rdy_seen = 1'b0;
      acc = 1'b0;
    end else begin
      acc = sti_TVALID && sti_TREADY;
      if (sto_TVALID && sto_TREADY && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (acc) q.push_back({sti_TDATA, sti_TKEEP, sti_TLAST});
      rdy_seen = 1'b1;
    end
  end

  task automatic drive(input bit v, input logic [PW-1:0] b);
    {sti_TDATA, sti_TKEEP, sti_TLAST} = b;
    sti_TVALID = v;
  endtask

  task automatic test_reset;
    logic [PW-1:0] a, b;
    a = PW'(19'h1A5A1);
    b = PW'(19'h2C3C0);
    #1;
    checks++; if (sto_TVALID !== 1'b0) begin errors++; $display("FAIL rst0_valid got %0b exp 0", sto_TVALID); end
    checks++; if (sti_TREADY !== 1'b0) begin errors++; $display("FAIL rst0_ready got %0b exp 0", sti_TREADY); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst0_occ got %0d exp 0", occ); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    checks++; if (sti_TREADY !== 1'b0) begin errors++; $display("FAIL rel_ready_pre got %0b exp 0", sti_TREADY); end
    @(negedge ACLK);
    checks++; if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL rel_ready_post got %0b exp 1", sti_TREADY); end
    sto_TREADY = 1'b0;
    drive(1'b1, a);
    @(negedge ACLK);
    drive(1'b1, b);
    @(negedge ACLK);
    drive(1'b0, '0);
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL rst_fill_occ got %0d exp 2", occ); end
    #2;
    ARESETn = 1'b0;
    #1;
    checks++; if (sto_TVALID !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b exp 0", sto_TVALID); end
    checks++; if (sti_TREADY !== 1'b0) begin errors++; $display("FAIL arst_ready got %0b exp 0", sti_TREADY); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL arst_occ got %0d exp 0", occ); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++; if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL arst_rel_ready got %0b exp 1", sti_TREADY); end
    checks++; if (sto_TVALID !== 1'b0) begin errors++; $display("FAIL arst_rel_valid got %0b exp 0", sto_TVALID); end
  endtask

  task automatic test_streaming;
    logic [PW-1:0] exp_b[16];
    for (int i = 0; i < 16; i++) exp_b[i] = {16'(i), 2'($urandom), (i == 15)};
    sto_TREADY = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge ACLK);
      if (i > 0) begin
        checks++; if (sto_TVALID !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, sto_TVALID); end
        checks++; if (sto !== exp_b[i-1]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, sto, exp_b[i-1]); end
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occ); end
        checks++; if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b exp 1", i, sti_TREADY); end
      end
      if (i < 16) drive(1'b1, exp_b[i]);
      else drive(1'b0, '0);
    end
    @(negedge ACLK);
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL stream_end_occ got %0d exp 0", occ); end
    checks++; if (sto_TVALID !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %0b exp 0", sto_TVALID); end
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] a, b, c;
    a = PW'(19'h0AAA3);
    b = PW'(19'h1BBB4);
    c = PW'(19'h3CCC7);
    sto_TREADY = 1'b0;
    drive(1'b1, a);
    @(negedge ACLK);
    checks++; if (sto !== a || occ !== 2'd1) begin errors++; $display("FAIL bp_a got %h/%0d exp %h/1", sto, occ, a); end
    drive(1'b1, b);
    @(negedge ACLK);
    checks++; if (sto !== a || occ !== 2'd2) begin errors++; $display("FAIL bp_full got %h/%0d exp %h/2", sto, occ, a); end
    checks++; if (sti_TREADY !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b exp 0", sti_TREADY); end
    drive(1'b1, c);
    @(negedge ACLK);
    checks++; if (sto !== a || occ !== 2'd2) begin errors++; $display("FAIL bp_hold got %h/%0d exp %h/2", sto, occ, a); end
    checks++; if (sti_TREADY !== 1'b0 || sto_TVALID !== 1'b1) begin errors++; $display("FAIL bp_hold_hs got %0b%0b exp 01", sti_TREADY, sto_TVALID); end
    sto_TREADY = 1'b1;
    @(negedge ACLK);
    checks++; if (sto !== b || occ !== 2'd1) begin errors++; $display("FAIL bp_b got %h/%0d exp %h/1", sto, occ, b); end
    checks++; if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL bp_reready got %0b exp 1", sti_TREADY); end
    @(negedge ACLK);
    checks++; if (sto !== c || occ !== 2'd1) begin errors++; $display("FAIL bp_c got %h/%0d exp %h/1", sto, occ, c); end
    drive(1'b0, '0);
    @(negedge ACLK);
    checks++; if (occ !== 2'd0 || sto_TVALID !== 1'b0) begin errors++; $display("FAIL bp_end got %0d/%0b exp 0/0", occ, sto_TVALID); end
  endtask

  task automatic test_drain;
    logic [PW-1:0] a, b;
    a = PW'(19'h12341);
    b = PW'(19'h56780);
    sto_TREADY = 1'b0;
    drive(1'b1, a);
    @(negedge ACLK);
    drive(1'b1, b);
    @(negedge ACLK);
    drive(1'b0, '0);
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL drain_full got %0d exp 2", occ); end
    sto_TREADY = 1'b1;
    @(negedge ACLK);
    checks++; if (occ !== 2'd1 || sto !== b) begin errors++; $display("FAIL drain_1 got %0d/%h exp 1/%h", occ, sto, b); end
    checks++; if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL drain_ready got %0b exp 1", sti_TREADY); end
    @(negedge ACLK);
    checks++; if (occ !== 2'd0 || sto_TVALID !== 1'b0) begin errors++; $display("FAIL drain_0 got %0d/%0b exp 0/0", occ, sto_TVALID); end
    @(negedge ACLK);
    checks++; if (occ !== 2'd0 || sto_TVALID !== 1'b0) begin errors++; $display("FAIL empty_idle got %0d/%0b exp 0/0", occ, sto_TVALID); end
  endtask

  task automatic test_random;
    int cyc, target;
    logic pv, pr;
    logic [PW-1:0] pb;
    cyc = 0;
    target = n_out + 10000;
    pv = 1'b0;
    pr = 1'b1;
    pb = '0;
    while (n_out < target && cyc < 80000) begin
      @(negedge ACLK);
      cyc++;
      checks++; if (sto_TVALID !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %0b exp %0b", cyc, sto_TVALID, q.size() > 0); end
      checks++; if (sti_TREADY !== (rdy_seen && q.size() < 2)) begin errors++; $display("FAIL rnd_ready c%0d got %0b exp %0b", cyc, sti_TREADY, q.size() < 2); end
      checks++; if (occ !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ c%0d got %0d exp %0d", cyc, occ, q.size()); end
      if (q.size() > 0) begin
        checks++; if (sto !== q[0]) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", cyc, sto, q[0]); end
      end
      if (pv && !pr) begin
        checks++; if (sto_TVALID !== 1'b1 || sto !== pb) begin errors++; $display("FAIL rnd_stable c%0d got %0b/%h exp 1/%h", cyc, sto_TVALID, sto, pb); end
      end
      if (!sti_TVALID || acc) drive(1'($urandom_range(0, 1)), PW'($urandom));
      sto_TREADY = 1'($urandom_range(0, 1));
      pv = sto_TVALID;
      pb = sto;
      pr = sto_TREADY;
    end
    checks++; if (n_out < target) begin errors++; $display("FAIL rnd_timeout got %0d exp %0d", n_out, target); end
    drive(1'b0, '0);
    sto_TREADY = 1'b1;
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_drain;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
